// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with frame-boundary double buffering.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  digit_en_i,
  input  logic [3:0]  dp_mask_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        pending_o,
  output logic        frame_done_o
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [15:0]     display_q, display_d;
  logic            pending_q, pending_d;
  logic            frame_done_q, frame_done_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic        tick;
  logic        commit;
  logic [3:0]  nibble;
  logic [3:0]  lz_blank;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0:    hex_glyph = 7'b1000000;
      4'h1:    hex_glyph = 7'b1111001;
      4'h2:    hex_glyph = 7'b0100100;
      4'h3:    hex_glyph = 7'b0110000;
      4'h4:    hex_glyph = 7'b0011001;
      4'h5:    hex_glyph = 7'b0010010;
      4'h6:    hex_glyph = 7'b0000010;
      4'h7:    hex_glyph = 7'b1111000;
      4'h8:    hex_glyph = 7'b0000000;
      4'h9:    hex_glyph = 7'b0010000;
      4'hA:    hex_glyph = 7'b0001000;
      4'hB:    hex_glyph = 7'b0000011;
      4'hC:    hex_glyph = 7'b1000110;
      4'hD:    hex_glyph = 7'b0100001;
      4'hE:    hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  assign tick   = (cnt_q == CntW'(REFRESH_DIV - 1));
  // Commit uses the pre-load shadow; a same-cycle load stays pending for the next frame.
  assign commit = tick && (idx_q == 2'd3) && pending_q;
  assign nibble = display_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (display_q[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (display_q[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (display_q[7:4] == 4'h0);
  end
`else
  assign lz_blank = 4'b0000;
`endif

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    shadow_d     = load_i ? value_i : shadow_q;
    display_d    = commit ? shadow_q : display_q;
    frame_done_d = commit;
    pending_d    = pending_q;
    if (commit) begin
      pending_d = load_i;
    end else if (load_i) begin
      pending_d = 1'b1;
    end

    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (digit_en_i[idx_q] && !lz_blank[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex_glyph(nibble);
      dp_d  = ~dp_mask_i[idx_q];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      display_q    <= 16'h0000;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign pending_o    = pending_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with REFRESH_DIV=4: directed stimulus pushes
// cycle-stamped expectations; a negedge monitor pops and compares them.
module tb_seg7_scan_driver;

  localparam bit LZ =
`ifdef SEG7_LZ_BLANK_EN
    1'b1;
`else
    1'b0;
`endif

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] OFF = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;
  logic        frame_done;

  seg7_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (load),
    .value_i      (value),
    .digit_en_i   (digit_en),
    .dp_mask_i    (dp_mask),
    .an_o         (an),
    .seg_o        (seg),
    .dp_o         (dp),
    .pending_o    (pending),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         stamp;
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pend;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_to(input int s);
    while (cyc < s) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int stamp, input string name, input logic [3:0] a,
                           input logic [6:0] s, input logic d, input logic p, input logic f);
    exp_t x;
    x.stamp = stamp; x.name = name; x.an = a; x.seg = s; x.dp = d; x.pend = p; x.fd = f;
    sb.push_back(x);
  endtask

  // A zero digit: lit with the "0" glyph, or fully blanked when leading-zero blanking is on.
  task automatic expect_zero(input int stamp, input string name, input logic [3:0] a,
                             input logic p, input logic f);
    expect_at(stamp, name, LZ ? 4'b1111 : a, LZ ? OFF : G0, 1'b1, p, f);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].stamp <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      if (e.stamp < cyc) begin
        n_bad++;
        $display("FAIL %s: check for cycle %0d was never reached (now %0d)", e.name, e.stamp,
                 cyc);
      end else if ({an, seg, dp, pending, frame_done} !== {e.an, e.seg, e.dp, e.pend, e.fd}) begin
        n_bad++;
        $display("FAIL %s @%0d: got an=%b seg=%b dp=%b pending=%b frame_done=%b, want an=%b seg=%b dp=%b pending=%b frame_done=%b",
                 e.name, cyc, an, seg, dp, pending, frame_done, e.an, e.seg, e.dp, e.pend, e.fd);
      end
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; value = 16'h0000; digit_en = 4'b1111; dp_mask = 4'b0000;
    wait_to(2);
    expect_at(cyc, "rst_hold", 4'b1111, OFF, 1'b1, 1'b0, 1'b0);
    wait_to(3);
    expect_at(cyc, "rst_hold2", 4'b1111, OFF, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    base = cyc;

    // Frame 0 shows zeros; 1234 is loaded mid-frame and committed at the first boundary.
    expect_at(base + 1, "rel_d0", 4'b1110, G0, 1'b1, 1'b0, 1'b0);
    expect_at(base + 3, "ld_pend", 4'b1110, G0, 1'b1, 1'b1, 1'b0);
    expect_zero(base + 5, "zero_d1", 4'b1101, 1'b1, 1'b0);
    expect_zero(base + 15, "pend_hold", 4'b0111, 1'b1, 1'b0);
    expect_zero(base + 16, "commit_1234", 4'b0111, 1'b0, 1'b1);
    expect_at(base + 17, "d0_4", 4'b1110, G4, 1'b1, 1'b0, 1'b0);
    expect_at(base + 21, "d1_3", 4'b1101, G3, 1'b1, 1'b0, 1'b0);
    expect_at(base + 25, "d2_2", 4'b1011, G2, 1'b1, 1'b0, 1'b0);
    expect_at(base + 29, "d3_1", 4'b0111, G1, 1'b1, 1'b0, 1'b0);
    expect_at(base + 32, "no_commit", 4'b0111, G1, 1'b1, 1'b0, 1'b0);
    wait_to(base + 2);
    load = 1'b1; value = 16'h1234;
    wait_to(base + 3);
    load = 1'b0;

    // Two loads within one frame: only the last one is committed.
    expect_at(base + 36, "old_d0", 4'b1110, G4, 1'b1, 1'b1, 1'b0);
    expect_at(base + 44, "old_d2", 4'b1011, G2, 1'b1, 1'b1, 1'b0);
    expect_at(base + 48, "commit_beef", 4'b0111, G1, 1'b1, 1'b0, 1'b1);
    expect_at(base + 49, "beef_d0", 4'b1110, GF, 1'b1, 1'b0, 1'b0);
    expect_at(base + 53, "beef_d1", 4'b1101, GE, 1'b1, 1'b0, 1'b0);
    expect_at(base + 57, "beef_d2", 4'b1011, GE, 1'b1, 1'b0, 1'b0);
    expect_at(base + 61, "beef_d3", 4'b0111, GB, 1'b1, 1'b0, 1'b0);
    expect_at(base + 64, "idle_bound", 4'b0111, GB, 1'b1, 1'b0, 1'b0);
    wait_to(base + 34);
    load = 1'b1; value = 16'hAAAA;
    wait_to(base + 35);
    load = 1'b0;
    wait_to(base + 39);
    load = 1'b1; value = 16'hBEEF;
    wait_to(base + 40);
    load = 1'b0;

    // 5578 pending; a load landing exactly on the boundary keeps pending high.
    expect_at(base + 70, "pend_5578", 4'b1101, GE, 1'b1, 1'b1, 1'b0);
    expect_at(base + 80, "ld_at_bound", 4'b1111, OFF, 1'b1, 1'b1, 1'b1);
    expect_at(base + 81, "en_d0_dp", 4'b1110, G8, 1'b0, 1'b1, 1'b0);
    expect_at(base + 85, "en_d1_off", 4'b1111, OFF, 1'b1, 1'b1, 1'b0);
    expect_at(base + 89, "en_d2", 4'b1011, G5, 1'b1, 1'b1, 1'b0);
    expect_at(base + 93, "en_d3_off", 4'b1111, OFF, 1'b1, 1'b1, 1'b0);
    expect_at(base + 96, "commit_9abc", 4'b1111, OFF, 1'b1, 1'b0, 1'b1);
    expect_at(base + 97, "abc_d0", 4'b1110, GC, 1'b1, 1'b0, 1'b0);
    expect_at(base + 101, "abc_d1", 4'b1101, GB, 1'b1, 1'b1, 1'b0);
    wait_to(base + 69);
    load = 1'b1; value = 16'h5578;
    wait_to(base + 70);
    load = 1'b0;
    wait_to(base + 78);
    digit_en = 4'b0101; dp_mask = 4'b0001;
    wait_to(base + 79);
    load = 1'b1; value = 16'h9ABC;
    wait_to(base + 80);
    load = 1'b0;
    wait_to(base + 96);
    digit_en = 4'b1111; dp_mask = 4'b0000;
    wait_to(base + 99);
    load = 1'b1; value = 16'h1111;
    wait_to(base + 100);
    load = 1'b0;

    // Reset mid-frame with a value pending: outputs clear without waiting for an edge.
    wait_to(base + 102);
    rst = 1'b1;
    expect_at(cyc, "rst_async", 4'b1111, OFF, 1'b1, 1'b0, 1'b0);
    wait_to(base + 104);
    expect_at(cyc, "rst_mid_hold", 4'b1111, OFF, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    base = cyc;

    expect_at(base + 1, "rst_d0", 4'b1110, G0, 1'b1, 1'b0, 1'b0);
    expect_zero(base + 5, "rst_d1", 4'b1101, 1'b0, 1'b0);
    expect_zero(base + 13, "rst_d3", 4'b0111, 1'b0, 1'b0);
    expect_zero(base + 16, "rst_no_fd", 4'b0111, 1'b0, 1'b0);
    expect_at(base + 17, "rst_d0b", 4'b1110, G0, 1'b1, 1'b0, 1'b0);
    expect_zero(base + 32, "commit_0042", 4'b0111, 1'b0, 1'b1);
    expect_at(base + 33, "v42_d0", 4'b1110, G2, 1'b1, 1'b0, 1'b0);
    expect_at(base + 37, "v42_d1", 4'b1101, G4, 1'b1, 1'b0, 1'b0);
    expect_zero(base + 41, "v42_d2", 4'b1011, 1'b1, 1'b0);
    expect_zero(base + 45, "v42_d3", 4'b0111, 1'b1, 1'b0);
    expect_zero(base + 48, "commit_1000", 4'b0111, 1'b0, 1'b1);
    expect_at(base + 49, "v1000_d0", 4'b1110, G0, 1'b1, 1'b0, 1'b0);
    expect_at(base + 53, "v1000_d1", 4'b1101, G0, 1'b1, 1'b0, 1'b0);
    expect_at(base + 57, "v1000_d2", 4'b1011, G0, 1'b1, 1'b0, 1'b0);
    expect_at(base + 61, "v1000_d3", 4'b0111, G1, 1'b1, 1'b0, 1'b0);
    wait_to(base + 17);
    load = 1'b1; value = 16'h0042;
    wait_to(base + 18);
    load = 1'b0;
    wait_to(base + 40);
    load = 1'b1; value = 16'h1000;
    wait_to(base + 41);
    load = 1'b0;

    wait_to(base + 64);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: check for cycle %0d left unevaluated", e.name, e.stamp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
